// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmit and receive controllers.
//   uart_tx_state_t : frame sequencing states of the transmit controller
//   UART_DBIT       : default data bits per frame
//   UART_OS         : default s_tick strobes per data bit (oversampling)
//   UART_SB_TICK    : default stop-period length in s_tick strobes
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DBIT    = 8;
    localparam int UART_OS      = 16;
    localparam int UART_SB_TICK = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Sequences one serial frame (start bit, DBIT data bits LSB-first, stop
// period) paced by the shared 16x oversampling strobe s_tick.
//
// Parameters
//   DBIT    : data bits per frame (5..8)
//   SB_TICK : stop-period length in s_tick strobes (16/24/32 = 1/1.5/2 stop)
//   OS      : s_tick strobes per data bit
// Ports
//   clk          in  : system clock, rising edge
//   reset_n      in  : asynchronous active-low reset
//   s_tick       in  : one-cycle baud strobe at OS x bit rate
//   tx_start     in  : send request, honoured only while idle
//   din          in  : byte to send, captured when tx_start is accepted
//   tx_busy      out : high whenever a frame is in progress
//   tx_done_tick out : one-cycle pulse on the final stop-period strobe
//   tx           out : registered serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT    = UART_DBIT,
    parameter int SB_TICK = UART_SB_TICK,
    parameter int OS      = UART_OS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    // One tick counter serves both the bit periods and the stop period, so it
    // is sized for whichever of the two is longer.
    localparam int SW = (OS > SB_TICK) ? $clog2(OS) : $clog2(SB_TICK);
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] OS_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    uart_tx_state_t  state, state_next;
    logic [SW-1:0]   s_cnt, s_next;
    logic [NW-1:0]   n_cnt, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            tx_reg, tx_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            s_cnt  <= '0;
            n_cnt  <= '0;
            b_reg  <= '0;
            tx_reg <= 1'b1;
        end else begin
            state  <= state_next;
            s_cnt  <= s_next;
            n_cnt  <= n_next;
            b_reg  <= b_next;
            tx_reg <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        s_next       = s_cnt;
        n_next       = n_cnt;
        b_next       = b_reg;
        tx_done_tick = 1'b0;

        case (state)
            IDLE: begin
                // The start bit begins right after acceptance without
                // waiting for s_tick, so it may run up to one tick short.
                if (tx_start) begin
                    b_next     = din;
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt == OS_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt == OS_LAST) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_cnt == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_cnt + 1'b1;
                        end
                    end else begin
                        s_next = s_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt == SB_LAST) begin
                        tx_done_tick = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        s_next = s_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes on the same
    // edge as the state; in DATA it follows the post-shift LSB.
    always_comb begin
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    localparam int DBIT        = 8;
    localparam int OS          = 16;
    localparam int SB_TICK     = 16;
    localparam int FRAME_TICKS = OS * (1 + DBIT) + SB_TICK;

    logic            clk;
    logic            reset_n;
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx_busy;
    logic            tx_done_tick;
    logic            tx;

    uart_tx_ctrl #(.DBIT(DBIT), .SB_TICK(SB_TICK), .OS(OS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .din          (din),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at time %0t", name, got, exp, $time);
    endtask

    // Tick source: s_tick high once every 'period' clocks.
    int period = 1;
    int tcnt   = 0;
    initial s_tick = 1'b0;
    always @(posedge clk) begin
        #1;
        tcnt++;
        if (tcnt >= period) begin
            tcnt   = 0;
            s_tick = 1'b1;
        end else begin
            s_tick = 1'b0;
        end
    end

    // Reference model: a frame is a fixed number of ticks long; requests are
    // taken only when no frame is running. m_k counts ticks consumed so far.
    logic            m_busy = 1'b0;
    int              m_k    = 0;
    logic [DBIT-1:0] m_byte = '0;
    logic [DBIT-1:0] exp_q[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_k    = 0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (tx_start) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_byte = din;
                exp_q.push_back(din);
            end
        end else if (s_tick) begin
            m_k++;
            if (m_k == FRAME_TICKS) m_busy = 1'b0;
        end
    end

    // Serial frame bit index idx: 0 = start, 1..DBIT = data LSB first, then stop.
    function automatic logic frame_bit(input logic [DBIT-1:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DBIT) return b[idx-1];
        return 1'b1;
    endfunction

    // Monitor: cycle-level comparison against the model plus frame-level
    // reconstruction popped against the scoreboard at each done pulse.
    int             obs_k = 0;
    int             cyc   = 0;
    logic [DBIT+1:0] obs_frame = '0;
    logic           exp_done;
    logic [DBIT-1:0] exp_byte;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("reset_tx", int'(tx), 1);
            check("reset_busy", int'(tx_busy), 0);
            check("reset_done", int'(tx_done_tick), 0);
            obs_k = 0;
            cyc   = 0;
        end else begin
            exp_done = m_busy && s_tick && (m_k == FRAME_TICKS - 1);
            check("busy", int'(tx_busy), int'(m_busy));
            check("done_tick", int'(tx_done_tick), int'(exp_done));
            check("tx_line", int'(tx), m_busy ? int'(frame_bit(m_byte, m_k / OS)) : 1);
            if (tx_busy) cyc++;
            if (tx_busy && s_tick) begin
                if (obs_k < FRAME_TICKS && (obs_k % OS) == OS / 2)
                    obs_frame[obs_k / OS] = tx;
                obs_k++;
            end
            if (tx_done_tick) begin
                check("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    exp_byte = exp_q.pop_front();
                    check("frame_data", int'(obs_frame[DBIT:1]), int'(exp_byte));
                end
                check("frame_start_bit", int'(obs_frame[0]), 0);
                check("frame_stop_bit", int'(obs_frame[DBIT+1]), 1);
                check("frame_ticks", obs_k, FRAME_TICKS);
                check("frame_clocks",
                      int'(cyc > (FRAME_TICKS - 1) * period && cyc <= FRAME_TICKS * period), 1);
                obs_k = 0;
                cyc   = 0;
            end
        end
    end

    task automatic send(input logic [DBIT-1:0] b);
        @(posedge clk); #1;
        tx_start = 1'b1;
        din      = b;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((m_busy || tx_busy) && i < budget) begin
            @(posedge clk);
            i++;
        end
        #1;
        check("idle_within_budget", int'(m_busy || tx_busy), 0);
    endtask

    initial begin
        int i;
        logic [DBIT-1:0] b;

        // Reset held with a pending request.
        reset_n  = 1'b0;
        tx_start = 1'b1;
        din      = 8'hA5;
        repeat (5) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        tx_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Continuous tick, 0xA5.
        period = 1;
        send(8'hA5);
        wait_idle(400);

        // Tick every 4th clock, 0x00.
        period = 4;
        send(8'h00);
        wait_idle(1500);
        period = 1;

        // Request during DATA is ignored.
        send(8'h5A);
        i = 0;
        while (m_k < OS * 3 && i < 400) begin @(posedge clk); i++; end
        #1;
        tx_start = 1'b1;
        din      = 8'hFF;
        @(posedge clk); #1;
        tx_start = 1'b0;
        wait_idle(400);
        repeat (20) @(posedge clk);
        #1;

        // Back-to-back with tx_start held high.
        @(posedge clk); #1;
        tx_start = 1'b1;
        din      = 8'h3C;
        @(posedge clk); #1;
        din      = 8'hC3;
        i = 0;
        while (m_busy && i < 400) begin @(posedge clk); #1; i++; end
        check("b2b_first_frame_done", int'(m_busy), 0);
        @(posedge clk); #1;
        tx_start = 1'b0;
        wait_idle(400);

        // Reset during data bit 3, then a clean frame.
        send(8'h96);
        i = 0;
        while (m_k < OS * 4 + 5 && i < 400) begin @(posedge clk); i++; end
        #3;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(8'h69);
        wait_idle(400);

        // Randomized frames, tick rates and ignored mid-frame requests.
        for (int f = 0; f < 6; f++) begin
            period = $urandom_range(1, 3);
            b = DBIT'($urandom);
            send(b);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(20, 100)) @(posedge clk);
                #1;
                tx_start = 1'b1;
                din      = DBIT'($urandom);
                @(posedge clk); #1;
                tx_start = 1'b0;
            end
            wait_idle(2000);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
